token_run_meter: RTL and testbench

- Downstream consumer of the serial token-doubling stage.
- Measures the length of every contiguous run of '1' tokens on a serial input.
- Queues each completed run length in a small FIFO and presents it on a valid/ready output for the control/checker logic.
- Flags a sticky overflow when a run exceeds the supported maximum or a completed length cannot be queued.

---
 rtl/token_pkg.sv | 14 +
 rtl/token_len_fifo.sv | 55 +++++
 rtl/token_run_meter.sv | 70 +++++++
 tb/tb_token_run_meter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/token_pkg.sv
// rtl/token_pkg.sv - shared defaults and length type for the token run meter
package token_pkg;

  localparam int DEF_MAX_RUN = 400;
  localparam int DEF_LEN_W   = $clog2(DEF_MAX_RUN + 1);
  localparam int DEF_DEPTH   = 4;

  typedef logic [DEF_LEN_W-1:0] len_t;

  function automatic int len_width(input int max_run);
    return $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/token_len_fifo.sv
// rtl/token_len_fifo.sv - small run-length FIFO with valid/ready head and drop flag
module token_len_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         full,
  output logic         drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_pop;
  logic          do_push;

  assign head_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign do_pop     = head_valid & pop_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push & (~full | do_pop);
  assign drop       = push & full & ~do_pop;
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/token_run_meter.sv
// rtl/token_run_meter.sv - measures runs of '1' tokens and queues their lengths
module token_run_meter
  import token_pkg::*;
#(
  parameter int MAX_RUN = DEF_MAX_RUN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic [LEN_W-1:0] len_data,
  output logic             len_valid,
  input  logic             len_ready,
  output logic             run_active,
  output logic             overflow
);

  if ((2 ** LEN_W) <= MAX_RUN) begin : g_bad_len_w
    $error("LEN_W too narrow for MAX_RUN");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [LEN_W-1:0] cnt;
  logic             at_max;
  logic             run_end;
  logic             fifo_full;
  logic             fifo_drop;

  assign at_max     = (cnt == LEN_W'(MAX_RUN));
  assign run_end    = ~a & (cnt != '0);
  assign run_active = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (a) begin
      if (!at_max) cnt <= cnt + LEN_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Sticky: saturation of the counter or a length lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if ((a & at_max) | fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  token_len_fifo #(
    .DEPTH (DEPTH),
    .W     (LEN_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (run_end),
    .push_data  (cnt),
    .pop_ready  (len_ready),
    .head_data  (len_data),
    .head_valid (len_valid),
    .full       (fifo_full),
    .drop       (fifo_drop)
  );

endmodule

// File: tb/tb_token_run_meter.sv
// tb/tb_token_run_meter.sv - randomized and directed bench for token_run_meter
module tb_token_run_meter;

  localparam int MAX_RUN = 400;
  localparam int LEN_W   = 9;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             a;
  logic             len_ready;
  logic [LEN_W-1:0] len_data;
  logic             len_valid;
  logic             run_active;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: current run length, queue of completed lengths, sticky flag.
  int run_len;
  int q[$];
  bit ovf;

  always #5 clk = ~clk;

  token_run_meter #(
    .MAX_RUN (MAX_RUN),
    .LEN_W   (LEN_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .len_data   (len_data),
    .len_valid  (len_valid),
    .len_ready  (len_ready),
    .run_active (run_active),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run_len = 0;
    q.delete();
    ovf = 1'b0;
  endtask

  task automatic model_step(input bit av, input bit rv);
    bit do_pop;
    bit was_full;
    do_pop   = (q.size() != 0) && rv;
    was_full = (q.size() == DEPTH);
    if (do_pop) void'(q.pop_front());
    if (av) begin
      if (run_len == MAX_RUN) ovf = 1'b1;
      else run_len++;
    end else if (run_len != 0) begin
      if (was_full && !do_pop) ovf = 1'b1;
      else q.push_back(run_len);
      run_len = 0;
    end
  endtask

  task automatic compare();
    check("len_valid", 32'(len_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("len_data", 32'(len_data), 32'(q[0]));
    check("run_active", 32'(run_active), 32'(run_len != 0));
    check("overflow", 32'(overflow), 32'(ovf));
  endtask

  task automatic cycle(input bit av, input bit rv);
    a = av;
    len_ready = rv;
    model_step(av, rv);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_len_valid"}, 32'(len_valid), 32'd0);
    check({tag, "_len_data"}, 32'(len_data), 32'd0);
    check({tag, "_run_active"}, 32'(run_active), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a = 1'b0;
    #1;
    check_cleared("rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int p_a;
    int p_r;
    rst = 1'b1;
    a = 1'b0;
    len_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_cleared("por");
    rst = 1'b0;

    // Single run of 3 with consumer ready.
    cycle(0, 1); cycle(1, 1); cycle(1, 1); cycle(1, 1); cycle(0, 1); cycle(0, 1);

    // Back-pressure then drain: lengths 1, 2, 4.
    cycle(1, 0); cycle(0, 0); cycle(1, 0); cycle(1, 0); cycle(0, 0);
    cycle(1, 0); cycle(1, 0); cycle(1, 0); cycle(1, 0); cycle(0, 0);
    repeat (4) cycle(0, 1);

    // Five runs into a four-entry FIFO; overflow must stay sticky afterwards.
    repeat (5) begin cycle(1, 0); cycle(0, 0); end
    repeat (5) cycle(0, 1);
    repeat (3) begin cycle(1, 1); cycle(0, 1); end
    do_reset();

    // Full FIFO with a push and pop on the same edge.
    repeat (4) begin cycle(1, 0); cycle(0, 0); end
    cycle(1, 0); cycle(1, 0); cycle(0, 1);
    repeat (5) cycle(0, 1);

    // Exactly MAX_RUN, then one beyond it.
    repeat (MAX_RUN) cycle(1, 1);
    cycle(0, 1); cycle(0, 1);
    repeat (MAX_RUN + 1) cycle(1, 1);
    cycle(0, 1); cycle(0, 1);
    do_reset();

    // Asynchronous reset between edges during a run with two entries queued.
    cycle(1, 0); cycle(0, 0); cycle(1, 0); cycle(0, 0);
    cycle(1, 0); cycle(1, 0); cycle(1, 0);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async");
    model_reset();
    a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 1); cycle(1, 1); cycle(0, 1); cycle(0, 1);

    // Randomized phases of token density and consumer readiness.
    p_a = 50;
    p_r = 50;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 64) == 0) begin
        case ($urandom_range(3))
          0: p_a = 20;
          1: p_a = 50;
          2: p_a = 80;
          default: p_a = 97;
        endcase
        case ($urandom_range(3))
          0: p_r = 0;
          1: p_r = 30;
          2: p_r = 70;
          default: p_r = 100;
        endcase
      end
      if ((i % 1000) == 999) do_reset();
      cycle($urandom_range(99) < p_a, $urandom_range(99) < p_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
